mnist_frame_sequencer: RTL and testbench
========================================

# mnist_frame_sequencer

Frame-level controller in front of `mnist_network_core`. After reset it holds off traffic for the core's weight-load window, then on each `start` admits exactly one 28×28 image from an upstream valid/ready pixel source. It forwards the pixels to the core as a registered valid stream and counts `result_valid` beats until the full 12×12 output map has been produced. It signals frame completion to the host/UART wrapper and optionally aborts a frame whose outputs stall.

## Interface
- `IMG_WIDTH`, 28, image columns
- `IMG_HEIGHT`, 28, image rows
- `DATA_WIDTH`, 8, pixel width
- `WEIGHT_LOAD_CYCLES`, 12000, cycles after reset before the core accepts pixels
- `DRAIN_TIMEOUT`, 4096, max cycles between result beats in DRAIN (timeout build only)
- Derived: IMG_PIXELS = IMG_WIDTH·IMG_HEIGHT (784); OUT_PIXELS = ((IMG_WIDTH−4)/2)·((IMG_HEIGHT−4)/2) (144); CW = $clog2(OUT_PIXELS+1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: begin one frame (sampled in READY only)
- `src_valid` in 1: upstream pixel valid
- `src_pixel` in DATA_WIDTH: upstream pixel
- `src_ready` out 1: sequencer accepts a pixel this cycle
- `core_valid_in` out 1: to core `valid_in`
- `core_pixel_in` out DATA_WIDTH: to core `pixel_in`
- `core_result_valid` in 1: from core `result_valid`
- `weights_ready` out 1: load window elapsed
- `busy` out 1: high in STREAM or DRAIN
- `frame_done` out 1: one-cycle pulse, frame complete
- `result_count` out CW: result beats counted in current/last frame
- `timeout_err` out 1: sticky drain-timeout flag

## Operation
- States: LOAD → READY → STREAM → DRAIN → READY.
- LOAD: entered on reset; counter runs 0..WEIGHT_LOAD_CYCLES−1, then go to READY with `weights_ready`=1 (remains 1 until reset). `start` ignored, not queued.
- READY: `start`=1 → STREAM; clear pixel counter, `result_count`, `timeout_err`.
- STREAM: `src_ready`=1. A beat is accepted when `src_valid`&&`src_ready`; pixel counter increments. On the IMG_PIXELS-th accepted beat → DRAIN (`src_ready` low from the next cycle). Source stalls (`src_valid`=0) produce gaps; `core_valid_in` is low during gaps.
- `result_count` increments on `core_result_valid` in STREAM or DRAIN (results can arrive during STREAM). Beats in LOAD/READY are ignored. The count saturates at OUT_PIXELS.
- DRAIN: when a beat makes `result_count` reach OUT_PIXELS (or count already equals it on entry) → pulse `frame_done`, go to READY. `result_count` holds its value until the next `start`.
- `start` during STREAM/DRAIN is ignored.
- `busy` = state∈{STREAM, DRAIN}.

## Timing
- Reset values: `src_ready`=0, `core_valid_in`=0, `core_pixel_in`=0, `weights_ready`=0, `busy`=0, `frame_done`=0, `result_count`=0, `timeout_err`=0; state LOAD; all counters 0.
- `weights_ready` rises exactly WEIGHT_LOAD_CYCLES rising edges after `rst` deasserts.
- Pixel path latency 1 cycle: an accepted beat at edge N appears on `core_valid_in`/`core_pixel_in` after edge N, for one cycle.
- `src_ready` is a registered state decode (no combinational path from `src_valid`).
- `frame_done` is asserted in the cycle after the edge that samples the final `core_result_valid`; the state is READY in that same cycle, so `start` may be asserted in it.
- An asynchronous `rst` mid-frame returns to LOAD immediately and reruns the full weight-load window. A partially sent frame is discarded.

## Configuration
- `MNIST_SEQ_TIMEOUT_EN` defined: in DRAIN a cycle counter resets on each `core_result_valid` beat. If it reaches DRAIN_TIMEOUT, set `timeout_err`=1 (sticky until next accepted `start` or reset) and go to READY without pulsing `frame_done`.
- Not defined: no watchdog. DRAIN waits indefinitely. `timeout_err` tied to 0.

## Test plan
- Reset, hold `start`=1 throughout → `weights_ready` rises at cycle 12000, `src_ready` stays 0 until after READY samples `start`.
- Full frame, `src_valid` always 1, pixels (i·3)&0xFF → exactly 784 `core_valid_in` pulses with matching data 1 cycle after acceptance. Then 144 results → single `frame_done`, `result_count`=144.
- Source drops `src_valid` every 3rd cycle → still exactly 784 forwarded pixels in order, and no `core_valid_in` during gaps.
- Inject an extra `core_result_valid` in READY, then 150 beats in the next frame → `result_count` saturates at 144, one `frame_done`.
- Assert `rst` after 400 pixels → all outputs at reset values, then `weights_ready` after another 12000 cycles, and the next frame completes normally.
- With `MNIST_SEQ_TIMEOUT_EN`, stop results at 100 → `timeout_err`=1 after 4096 cycles, state READY, no `frame_done`. Next `start` clears it.

Source files
------------

// File: rtl/mnist_frame_sequencer.sv
// Frame sequencer in front of mnist_network_core: weight-load hold-off, one image per start, result counting.
// Optional drain watchdog enabled by defining MNIST_SEQ_TIMEOUT_EN.
module mnist_frame_sequencer #(
  parameter int IMG_WIDTH          = 28,
  parameter int IMG_HEIGHT         = 28,
  parameter int DATA_WIDTH         = 8,
  parameter int WEIGHT_LOAD_CYCLES = 12000,
`ifdef MNIST_SEQ_TIMEOUT_EN
  parameter int DRAIN_TIMEOUT      = 4096,
`endif
  localparam int IMG_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  localparam int OUT_PIXELS = ((IMG_WIDTH - 4) / 2) * ((IMG_HEIGHT - 4) / 2),
  localparam int CW         = $clog2(OUT_PIXELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_pixel,
  output logic                  src_ready,
  output logic                  core_valid_in,
  output logic [DATA_WIDTH-1:0] core_pixel_in,
  input  logic                  core_result_valid,
  output logic                  weights_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CW-1:0]         result_count,
  output logic                  timeout_err
);

  localparam int LW = $clog2(WEIGHT_LOAD_CYCLES + 1);
  localparam int PW = $clog2(IMG_PIXELS + 1);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         load_cnt_q, load_cnt_d;
  logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]         res_cnt_q, res_cnt_d;
  logic                  src_ready_q, src_ready_d;
  logic                  core_valid_q, core_valid_d;
  logic [DATA_WIDTH-1:0] core_pixel_q, core_pixel_d;
  logic                  weights_ready_q, weights_ready_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  accept;

`ifdef MNIST_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  logic [TW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                  timeout_q, timeout_d;
`endif

  assign accept = src_valid && src_ready_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d         = state_q;
    load_cnt_d      = load_cnt_q;
    pix_cnt_d       = pix_cnt_q;
    res_cnt_d       = res_cnt_q;
    weights_ready_d = weights_ready_q;
    core_valid_d    = 1'b0;
    core_pixel_d    = core_pixel_q;
    frame_done_d    = 1'b0;
`ifdef MNIST_SEQ_TIMEOUT_EN
    drain_cnt_d     = drain_cnt_q;
    timeout_d       = timeout_q;
`endif

    // Results may land while pixels are still streaming; the count never exceeds one map.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && core_result_valid &&
        res_cnt_q != CW'(OUT_PIXELS))
      res_cnt_d = res_cnt_q + 1'b1;

    case (state_q)
      S_LOAD: begin
        if (load_cnt_q == LW'(WEIGHT_LOAD_CYCLES - 1)) begin
          state_d         = S_READY;
          weights_ready_d = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      S_READY: begin
        if (start) begin
          state_d   = S_STREAM;
          pix_cnt_d = '0;
          res_cnt_d = '0;
`ifdef MNIST_SEQ_TIMEOUT_EN
          drain_cnt_d = '0;
          timeout_d   = 1'b0;
`endif
        end
      end
      S_STREAM: begin
        if (accept) begin
          core_valid_d = 1'b1;
          core_pixel_d = src_pixel;
          pix_cnt_d    = pix_cnt_q + 1'b1;
          if (pix_cnt_q == PW'(IMG_PIXELS - 1))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_cnt_d == CW'(OUT_PIXELS)) begin
          frame_done_d = 1'b1;
          state_d      = S_READY;
        end
`ifdef MNIST_SEQ_TIMEOUT_EN
        else if (core_result_valid) begin
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == TW'(DRAIN_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_READY;
          end
        end
`endif
      end
      default: state_d = S_LOAD;
    endcase

    src_ready_d = (state_d == S_STREAM);
    busy_d      = (state_d == S_STREAM) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_LOAD;
      load_cnt_q      <= '0;
      pix_cnt_q       <= '0;
      res_cnt_q       <= '0;
      src_ready_q     <= 1'b0;
      core_valid_q    <= 1'b0;
      core_pixel_q    <= '0;
      weights_ready_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
`ifdef MNIST_SEQ_TIMEOUT_EN
      drain_cnt_q     <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q         <= state_d;
      load_cnt_q      <= load_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      res_cnt_q       <= res_cnt_d;
      src_ready_q     <= src_ready_d;
      core_valid_q    <= core_valid_d;
      core_pixel_q    <= core_pixel_d;
      weights_ready_q <= weights_ready_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
`ifdef MNIST_SEQ_TIMEOUT_EN
      drain_cnt_q     <= drain_cnt_d;
      timeout_q       <= timeout_d;
`endif
    end
  end

  assign src_ready     = src_ready_q;
  assign core_valid_in = core_valid_q;
  assign core_pixel_in = core_pixel_q;
  assign weights_ready = weights_ready_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign result_count  = res_cnt_q;
`ifdef MNIST_SEQ_TIMEOUT_EN
  assign timeout_err   = timeout_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// Scoreboard bench for mnist_frame_sequencer: stimulus queues expected pixels/completions, a monitor checks them.
module tb_mnist_frame_sequencer;

  localparam int WLC        = 12000;
  localparam int IMG_PIXELS = 784;
  localparam int OUT_PIXELS = 144;
  localparam int CW         = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b1;
  logic          src_valid = 1'b0;
  logic [7:0]    src_pixel = '0;
  logic          src_ready;
  logic          core_valid_in;
  logic [7:0]    core_pixel_in;
  logic          core_result_valid = 1'b0;
  logic          weights_ready;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] result_count;
  logic          timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int fwd_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_pix[$];
  int         exp_done[$];

  mnist_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .src_valid(src_valid), .src_pixel(src_pixel), .src_ready(src_ready),
    .core_valid_in(core_valid_in), .core_pixel_in(core_pixel_in),
    .core_result_valid(core_result_valid), .weights_ready(weights_ready),
    .busy(busy), .frame_done(frame_done), .result_count(result_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every forwarded pixel and every frame_done must match a queued expectation.
  initial begin
    logic [7:0] ep;
    int         ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (core_valid_in) begin
          if (exp_pix.size() == 0) check("spurious_core_valid", core_valid_in, 0);
          else begin
            ep = exp_pix.pop_front();
            check("core_pixel", core_pixel_in, ep);
            fwd_cnt++;
          end
        end
        if (frame_done) begin
          done_cnt++;
          if (exp_done.size() == 0) check("spurious_frame_done", frame_done, 0);
          else begin
            ed = exp_done.pop_front();
            check("done_result_count", result_count, ed);
            check("done_busy", busy, 0);
          end
        end
      end
    end
  end

  // Entered with rst just released between edges; returns #1 after edge WLC.
  task automatic wait_load();
    logic any_ready = 1'b0;
    for (int i = 1; i < WLC; i++) begin
      @(posedge clk); #1;
      any_ready |= src_ready;
      core_result_valid = (i >= 10 && i < 20);
    end
    core_result_valid = 1'b0;
    check("weights_ready_before", weights_ready, 0);
    @(posedge clk); #1;
    check("weights_ready_at_wlc", weights_ready, 1);
    check("src_ready_in_load", any_ready | src_ready, 0);
    check("busy_in_load", busy, 0);
    check("load_results_ignored", result_count, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_src_ready", src_ready, 1);
    check("start_busy", busy, 1);
    check("start_clears_count", result_count, 0);
  endtask

  task automatic stream_pixels(input bit gap, input int n);
    int sent = 0;
    int cyc = 0;
    bit v;
    while (sent < n && cyc < 4 * n + 16) begin
      v = gap ? ((cyc % 3) != 2) : 1'b1;
      src_valid = v;
      src_pixel = 8'((sent * 3) & 255);
      if (v && src_ready) begin
        exp_pix.push_back(src_pixel);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    src_valid = 1'b0;
    check("pixels_accepted", sent, n);
  endtask

  task automatic send_results(input int n);
    for (int i = 0; i < n; i++) begin
      core_result_valid = 1'b1;
      @(posedge clk); #1;
    end
    core_result_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic full_frame(input bit gap, input int n_results);
    int fbase = fwd_cnt;
    int dbase = done_cnt;
    stream_pixels(gap, IMG_PIXELS);
    check("drain_src_ready", src_ready, 0);
    exp_done.push_back(OUT_PIXELS);
    send_results(n_results);
    check("frame_pixel_count", fwd_cnt - fbase, IMG_PIXELS);
    check("frame_done_once", done_cnt - dbase, 1);
    check("final_result_count", result_count, OUT_PIXELS);
    check("final_busy", busy, 0);
  endtask

  initial begin
    // Reset with start held high: start must not be queued during the load window.
    @(negedge clk);
    check("rst_src_ready", src_ready, 0);
    check("rst_core_valid", core_valid_in, 0);
    check("rst_core_pixel", core_pixel_in, 0);
    check("rst_weights_ready", weights_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_result_count", result_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    wait_load();
    do_start();
    full_frame(1'b0, OUT_PIXELS);

    // Source gaps every third cycle.
    do_start();
    full_frame(1'b1, OUT_PIXELS);

    // Extra beat in READY, then an over-long result burst saturates.
    core_result_valid = 1'b1;
    @(posedge clk); #1;
    core_result_valid = 1'b0;
    check("ready_beat_ignored", result_count, OUT_PIXELS);
    do_start();
    full_frame(1'b0, 150);

    // Reset in the middle of a frame.
    do_start();
    stream_pixels(1'b1, 400);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    exp_pix.delete();
    check("mid_rst_src_ready", src_ready, 0);
    check("mid_rst_core_valid", core_valid_in, 0);
    check("mid_rst_core_pixel", core_pixel_in, 0);
    check("mid_rst_weights_ready", weights_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result_count", result_count, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_load();
    do_start();
    full_frame(1'b1, OUT_PIXELS);

`ifdef MNIST_SEQ_TIMEOUT_EN
    begin
      int dbase;
      int w = 0;
      do_start();
      stream_pixels(1'b0, IMG_PIXELS);
      dbase = done_cnt;
      send_results(100);
      while (busy && w < 5000) begin
        @(posedge clk); #1;
        w++;
      end
      check("timeout_busy", busy, 0);
      check("timeout_err_set", timeout_err, 1);
      check("timeout_no_done", done_cnt - dbase, 0);
      check("timeout_window", (w >= 4085 && w <= 4100), 1);
      do_start();
      check("timeout_err_cleared", timeout_err, 0);
      full_frame(1'b0, OUT_PIXELS);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
